// File: rtl/zombie_sprite_blitter_if.sv
// zombie_sprite_blitter_if: draw command, sprite ROM, palette and frame-buffer signals of the blitter.
interface zombie_sprite_blitter_if;
    logic        start;
    logic [10:0] sprite_x;
    logic [10:0] sprite_y;
    logic [2:0]  frame_sel;
    logic        busy;
    logic        done;
    logic [12:0] rom_addr;
    logic [2:0]  rom_data;
    logic [2:0]  pal_index;
    logic [15:0] pal_color;
    logic [18:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_we;
    logic        fb_ready;
    modport slave (
        input  start, sprite_x, sprite_y, frame_sel, rom_data, pal_color, fb_ready,
        output busy, done, rom_addr, pal_index, fb_addr, fb_data, fb_we
    );
    modport master (
        output start, sprite_x, sprite_y, frame_sel, rom_data, pal_color, fb_ready,
        input  busy, done, rom_addr, pal_index, fb_addr, fb_data, fb_we
    );
endinterface

// File: rtl/zombie_sprite_blitter.sv
// zombie_sprite_blitter: walks one sprite frame in raster order, writing opaque on-screen pixels to the frame buffer.
module zombie_sprite_blitter #(
    parameter int SPRITE_W          = 32,
    parameter int SPRITE_H          = 32,
    parameter int NUM_FRAMES        = 8,
    parameter int SCREEN_W          = 640,
    parameter int SCREEN_H          = 480,
    parameter int TRANSPARENT_INDEX = 7
) (
    input logic Clk,
    input logic Reset,
    zombie_sprite_blitter_if.slave bus
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam logic [2:0] TI = 3'(TRANSPARENT_INDEX);
    localparam logic signed [11:0] SX_MAX = 12'(SCREEN_W);
    localparam logic signed [11:0] SY_MAX = 12'(SCREEN_H);

    typedef enum logic [2:0] {IDLE, FETCH, READ, WRITE, DONE} state_e;

    state_e state_q, state_d;
    logic [RW-1:0] row_q, row_d, row_n;
    logic [CW-1:0] col_q, col_d, col_n;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [2:0] frame_q, frame_d;
    logic [12:0] rom_addr_q, rom_addr_d;
    logic [18:0] fb_addr_q, fb_addr_d;
    logic [15:0] fb_data_q, fb_data_d;
    logic signed [11:0] sx, sy;
    logic skip, adv, last;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
            rom_addr_q <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            x_q        <= x_d;
            y_q        <= y_d;
            frame_q    <= frame_d;
            rom_addr_q <= rom_addr_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    always_comb begin
        sx = {x_q[10], x_q} + 12'(col_q);
        sy = {y_q[10], y_q} + 12'(row_q);
        skip = bus.rom_data == TI || sx < 0 || sx >= SX_MAX || sy < 0 || sy >= SY_MAX;
        adv = (state_q == READ && skip) || (state_q == WRITE && bus.fb_ready);
        last = &row_q && &col_q;
        col_n = col_q + CW'(1);
        row_n = &col_q ? row_q + RW'(1) : row_q;
        state_d = state_q;
        row_d = row_q;
        col_d = col_q;
        x_d = x_q;
        y_d = y_q;
        frame_d = frame_q;
        rom_addr_d = rom_addr_q;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        case (state_q)
            IDLE: if (bus.start) begin
                x_d = bus.sprite_x;
                y_d = bus.sprite_y;
                frame_d = bus.frame_sel;
                row_d = '0;
                col_d = '0;
                rom_addr_d = {bus.frame_sel, {(RW + CW){1'b0}}};
                state_d = FETCH;
            end
            FETCH: state_d = READ;
            READ: if (!skip) begin
                fb_addr_d = 19'(sy) * 19'(SCREEN_W) + 19'(sx);
                fb_data_d = bus.pal_color;
                state_d = WRITE;
            end
            DONE: state_d = IDLE;
            default: ;
        endcase
        // The address for the next pixel is loaded as we enter FETCH so the synchronous ROM answers in READ.
        if (adv) begin
            col_d = col_n;
            row_d = row_n;
            state_d = last ? DONE : FETCH;
            rom_addr_d = last ? rom_addr_q : {frame_q, row_n, col_n};
        end
    end

    always_comb begin
        bus.busy = state_q != IDLE;
        bus.done = state_q == DONE;
        bus.fb_we = state_q == WRITE;
        bus.rom_addr = rom_addr_q;
        bus.pal_index = bus.rom_data;
        bus.fb_addr = fb_addr_q;
        bus.fb_data = fb_data_q;
    end
endmodule

// File: doc/zombie_sprite_blitter.md
Name: zombie_sprite_blitter

Overview:
- Draws one zombie sprite into the frame buffer per command.
- Walks the sprite ROM pixel by pixel and feeds each 3-bit colour index to the zombie palette lookup (combinational, external).
- Writes the returned RGB565 colour to the frame-buffer write port, skipping transparent and off-screen pixels.
- Sits between the game-logic draw scheduler (upstream) and the palette and frame-buffer arbiter (downstream).

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels (power of two)
- NUM_FRAMES, 8, animation/direction frames stored back-to-back in ROM
- SCREEN_W, 640, frame-buffer width
- SCREEN_H, 480, frame-buffer height
- TRANSPARENT_INDEX, 7, palette index that is never written

Ports:
- Clk  in  1  system clock, all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle draw request; ignored while busy=1
- sprite_x  in  11  signed screen X of sprite top-left; sampled on accepted start
- sprite_y  in  11  signed screen Y of sprite top-left; sampled on accepted start
- frame_sel  in  3  sprite frame number; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start through the DONE state
- done  out  1  one-cycle pulse when the sprite is finished
- rom_addr  out  13  sprite ROM address = frame*SPRITE_W*SPRITE_H + row*SPRITE_W + col
- rom_data  in  3  sprite ROM output, valid one cycle after rom_addr (synchronous ROM)
- pal_index  out  3  palette index; equals rom_data
- pal_color  in  16  RGB565 colour from the palette for pal_index, combinational
- fb_addr  out  19  frame-buffer word address = y*SCREEN_W + x
- fb_data  out  16  pixel colour
- fb_we  out  1  write request
- fb_ready  in  1  arbiter accepts the write on any rising edge where fb_we=1 and fb_ready=1

Behaviour:
- Reset values: busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, rom_addr=0; state=IDLE; row and col counters cleared.
- Reset takes effect at any point, including mid-sprite: the block returns to IDLE with no further writes and does not pulse done.
- States: IDLE, FETCH, READ, WRITE, DONE.
- IDLE:
  - On start=1, latch sprite_x, sprite_y and frame_sel; clear row and col; go to FETCH.
  - start is ignored in every other state (no queueing).
- FETCH: rom_addr is registered for the current row/col; go to READ.
- READ: rom_data is now valid and drives pal_index.
  - Screen coordinates: sx = sprite_x + col, sy = sprite_y + row, computed as 12-bit signed.
  - Skip the pixel if rom_data == TRANSPARENT_INDEX, or sx < 0, or sx >= SCREEN_W, or sy < 0, or sy >= SCREEN_H.
  - If skipped: advance.
  - If not skipped: register fb_addr = sy*SCREEN_W + sx, fb_data = pal_color, fb_we=1; go to WRITE.
- WRITE:
  - Hold fb_we, fb_addr and fb_data stable until fb_ready=1 is sampled.
  - On that edge, drop fb_we and advance. Stall is unbounded.
- Advance:
  - If col == SPRITE_W-1: col=0, row++; otherwise col++.
  - If the pixel just handled was row == SPRITE_H-1 and col == SPRITE_W-1, go to DONE; otherwise go to FETCH.
- DONE: done=1 for exactly one cycle, busy=1; then IDLE with busy=0.
- busy timing: busy=1 in FETCH, READ, WRITE and DONE.
- Throughput:
  - A skipped pixel costs 2 cycles.
  - A written pixel costs 3 cycles, plus one cycle per fb_ready stall.
  - Fully transparent 32x32 sprite: 2048 cycles from first FETCH to DONE.
- Arithmetic: fb_addr product fits 19 bits (max 307199); rom_addr wraps modulo 8192 (frame_sel max 7 → max addr 8191).
- Pixel order: raster, row-major, top-left first. Each on-screen opaque pixel is written exactly once.

Test Plan:
- Reset mid-draw: assert Reset in WRITE with fb_ready=0 → next cycle fb_we=0, busy=0, state IDLE, no done pulse.
- Opaque sprite at (100,50), frame 0, ROM all index 3, fb_ready=1:
  - 1024 writes, each fb_data=16'h5B4E.
  - First fb_addr=32100, last fb_addr=81*640+131=51971.
  - done pulses once; total ~3073 cycles.
- Transparent sprite, ROM all index 7 → zero fb_we cycles; done pulses 2049 cycles after the start edge.
- Clipping at sprite_x=-16, sprite_y=470, ROM all index 0 → exactly 16x10=160 writes, x 0..15, y 470..479; first fb_addr=300800.
- Backpressure: fb_ready low for 5 cycles on the first write → fb_addr/fb_data/fb_we stable throughout; a start pulse during the draw is ignored; the pixel is written once after fb_ready rises.
- Frame select: frame_sel=5 → first rom_addr=5120, last rom_addr=6143.
